// File: rtl/sp_ram_param.sv
// Single-port RAM with post-reset zero sweep; WR_MODE selects read-first/write-first/no-change.
// Read latency 1 cycle, or 2 cycles when SP_RAM_OUT_REG_EN is defined (extra output register).
// No backpressure: one access per cycle accepted in READY, requests dropped while busy.
module sp_ram_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int WR_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              rd_valid,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdat;
    logic [DATA_W-1:0]  rdat_q, rdat_d;
    logic               rvld_q, rvld_d;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdat  = datain;
        rdat_d    = rdat_q;
        rvld_d    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdat  = '0;
                ptr_d     = ptr_q + 1'b1;
                if (&ptr_q) state_d = S_READY;
            end
            S_READY: begin
                if (cs) begin
                    if (we) begin
                        mem_we = 1'b1;
                        // Out-of-range modes fall through to read-first.
                        case (WR_MODE)
                            1: begin
                                rdat_d = datain;
                                rvld_d = 1'b1;
                            end
                            2: ;
                            default: begin
                                rdat_d = mem_q[addr];
                                rvld_d = 1'b1;
                            end
                        endcase
                    end else begin
                        rdat_d = mem_q[addr];
                        rvld_d = 1'b1;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            rdat_q  <= '0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rdat_q  <= rdat_d;
            rvld_q  <= rvld_d;
        end
    end

    // Storage is not reset; the sweep clears it, and reset cycles must not write.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdat;
    end

`ifdef SP_RAM_OUT_REG_EN
    logic [DATA_W-1:0] dout2_q;
    logic              vld2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout2_q <= '0;
            vld2_q  <= 1'b0;
        end else begin
            dout2_q <= rdat_q;
            vld2_q  <= rvld_q;
        end
    end

    assign dataout  = dout2_q;
    assign rd_valid = vld2_q;
`else
    assign dataout  = rdat_q;
    assign rd_valid = rvld_q;
`endif

    assign busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_sp_ram_param.sv
// Bench for sp_ram_param: three instances (WR_MODE 0/1/2) share stimulus; a queue scoreboard
// holds the expected output per access, compared when the result is due.
module tb_sp_ram_param;
`ifdef SP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       we;
    logic [3:0] addr;
    logic [7:0] datain;
    logic [7:0] dout [3];
    logic       vld  [3];
    logic       bsy  [3];

    typedef struct {
        int             due;
        logic [2:0]     v;
        logic [2:0][7:0] d;
    } exp_t;

    exp_t       q[$];
    logic [7:0] held [3];
    int         cyc    = 0;
    int         checks = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    sp_ram_param #(.DATA_W(8), .ADDR_W(4), .WR_MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .datain(datain),
        .dataout(dout[0]), .rd_valid(vld[0]), .busy(bsy[0]));
    sp_ram_param #(.DATA_W(8), .ADDR_W(4), .WR_MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .datain(datain),
        .dataout(dout[1]), .rd_valid(vld[1]), .busy(bsy[1]));
    sp_ram_param #(.DATA_W(8), .ADDR_W(4), .WR_MODE(2)) u_m2 (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .datain(datain),
        .dataout(dout[2]), .rd_valid(vld[2]), .busy(bsy[2]));

    task automatic drive(input logic c, input logic w, input logic [3:0] a, input logic [7:0] d);
        cs     = c;
        we     = w;
        addr   = a;
        datain = d;
    endtask

    // Expected result of the access driven now; bit i of v / d[i] belong to WR_MODE i.
    task automatic expect_out(input logic [2:0] v, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2);
        exp_t e;
        e.due  = cyc + LAT;
        e.v    = v;
        e.d[0] = d0;
        e.d[1] = d1;
        e.d[2] = d2;
        q.push_back(e);
    endtask

    task automatic tick();
        logic       hit;
        logic       vexp;
        logic [7:0] dexp;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 3; i++) held[i] = 8'h00;
        end
        @(negedge clk);
        hit = (q.size() > 0) && (q[0].due == cyc);
        for (int i = 0; i < 3; i++) begin
            vexp = hit ? q[0].v[i] : 1'b0;
            dexp = (hit && q[0].v[i]) ? q[0].d[i] : held[i];
            checks++;
            assert (vld[i] === vexp) else begin
                fails++;
                $error("FAIL rd_valid mode%0d cyc%0d got %b exp %b", i, cyc, vld[i], vexp);
            end
            checks++;
            assert (dout[i] === dexp) else begin
                fails++;
                $error("FAIL dataout mode%0d cyc%0d got %h exp %h", i, cyc, dout[i], dexp);
            end
            held[i] = dexp;
        end
        if (hit) void'(q.pop_front());
    endtask

    task automatic check_busy(input logic e, input string tag);
        for (int i = 0; i < 3; i++) begin
            checks++;
            assert (bsy[i] === e) else begin
                fails++;
                $error("FAIL %s busy mode%0d got %b exp %b", tag, i, bsy[i], e);
            end
        end
    endtask

    // Counts ticks after reset release until busy drops; must be exactly 16.
    task automatic sweep_wait(input string tag);
        int fall [3];
        for (int i = 0; i < 3; i++) fall[i] = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            for (int i = 0; i < 3; i++) if (fall[i] == 0 && bsy[i] === 1'b0) fall[i] = n;
            if (fall[0] != 0 && fall[1] != 0 && fall[2] != 0) break;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            assert (fall[i] === 16) else begin
                fails++;
                $error("FAIL %s busy_len mode%0d got %0d exp 16", tag, i, fall[i]);
            end
        end
    endtask

    initial begin
        logic [7:0] val;
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        tick();
        check_busy(1'b1, "reset");

        // Power-up sweep with reads pending; reads ignored while busy.
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'd5, 8'h00);
        sweep_wait("sweep1");
        expect_out(3'b111, 8'h00, 8'h00, 8'h00);
        tick();

        // Write then back-to-back read.
        drive(1'b1, 1'b1, 4'd3, 8'hA5);
        expect_out(3'b011, 8'h00, 8'hA5, 8'h00);
        tick();
        drive(1'b1, 1'b0, 4'd3, 8'h00);
        expect_out(3'b111, 8'hA5, 8'hA5, 8'hA5);
        tick();

        // Overwrite: read-first / write-first / no-change behaviour.
        drive(1'b1, 1'b1, 4'd3, 8'h3C);
        expect_out(3'b011, 8'hA5, 8'h3C, 8'h00);
        tick();
        drive(1'b1, 1'b0, 4'd3, 8'h00);
        expect_out(3'b111, 8'h3C, 8'h3C, 8'h3C);
        tick();

        // Deselected write must not land.
        drive(1'b0, 1'b1, 4'd3, 8'h11);
        tick();
        drive(1'b1, 1'b0, 4'd3, 8'h00);
        expect_out(3'b111, 8'h3C, 8'h3C, 8'h3C);
        tick();
        check_busy(1'b0, "ready");

        drive(1'b1, 1'b1, 4'd15, 8'hFF);
        expect_out(3'b011, 8'h00, 8'hFF, 8'h00);
        tick();
        drive(1'b1, 1'b0, 4'd15, 8'h00);
        expect_out(3'b111, 8'hFF, 8'hFF, 8'hFF);
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        tick();

        // Reset from READY, then reset again at sweep pointer 7; writes during busy dropped.
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'd15, 8'hEE);
        tick();
        check_busy(1'b1, "rst_ready");
        rst = 1'b0;
        for (int n = 0; n < 7; n++) tick();
        check_busy(1'b1, "mid_sweep");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_wait("sweep2");
        drive(1'b1, 1'b0, 4'd15, 8'h00);
        expect_out(3'b111, 8'h00, 8'h00, 8'h00);
        tick();
        drive(1'b1, 1'b0, 4'd3, 8'h00);
        expect_out(3'b111, 8'h00, 8'h00, 8'h00);
        tick();

        // Fill every address, then read all back with no gaps.
        for (int i = 0; i < 16; i++) begin
            val = 8'(i * 37 + 1);
            drive(1'b1, 1'b1, 4'(i), val);
            expect_out(3'b011, 8'h00, val, 8'h00);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            val = 8'(i * 37 + 1);
            drive(1'b1, 1'b0, 4'(i), 8'h00);
            expect_out(3'b111, val, val, val);
            tick();
        end

        drive(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        tick();
        checks++;
        assert (q.size() == 0) else begin
            fails++;
            $error("FAIL drain pending got %0d exp 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
